piradma_mm2s_burst_sched: RTL

PIRADMA_MM2S_BURST_SCHED -- requirements
Module: piradma_mm2s_burst_sched

---
 rtl/piradma_mm2s_burst_sched_if.sv | 35 +++
 rtl/piradma_mm2s_burst_sched.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/piradma_mm2s_burst_sched_if.sv
// Descriptor-in / read-command-out bundle for the MM2S burst scheduler.
// slave  : scheduler side (accepts descriptors, issues commands, receives rdone)
// master : environment side (supplies descriptors, accepts commands, pulses rdone)
// Signals: desc_tvalid/desc_tready/desc_base/desc_len, cmd_tvalid/cmd_tready/
//          cmd_addr/cmd_len/cmd_last, rdone, desc_done, busy, err.
interface piradma_mm2s_burst_sched_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 32
);
   logic                  desc_tvalid;
   logic                  desc_tready;
   logic [ADDR_WIDTH-1:0] desc_base;
   logic [LEN_WIDTH-1:0]  desc_len;
   logic                  cmd_tvalid;
   logic                  cmd_tready;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [7:0]            cmd_len;
   logic                  cmd_last;
   logic                  rdone;
   logic                  desc_done;
   logic                  busy;
   logic                  err;

   modport slave (
      input  desc_tvalid, desc_base, desc_len, cmd_tready, rdone,
      output desc_tready, cmd_tvalid, cmd_addr, cmd_len, cmd_last,
             desc_done, busy, err
   );

   modport master (
      output desc_tvalid, desc_base, desc_len, cmd_tready, rdone,
      input  desc_tready, cmd_tvalid, cmd_addr, cmd_len, cmd_last,
             desc_done, busy, err
   );
endinterface

// File: rtl/piradma_mm2s_burst_sched.sv
// MM2S burst scheduler: splits one byte-range descriptor at a time into AXI-style
// read bursts (ARLEN encoding) that never exceed MAX_BURST beats or cross a 4 KB
// boundary, throttles issue to MAX_OUTSTANDING in-flight bursts, and pulses
// desc_done once every burst of the descriptor has completed.
// Ports: aclk, aresetn (async active-low), bus (slave modport of the _if bundle).
// All outputs are registered.
module piradma_mm2s_burst_sched #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned LEN_WIDTH       = 32,
   parameter int unsigned DATA_BYTES      = 8,
   parameter int unsigned MAX_BURST       = 16,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input logic                           aclk,
   input logic                           aresetn,
   piradma_mm2s_burst_sched_if.slave     bus
);

   localparam int unsigned OFF_W = $clog2(DATA_BYTES);
   localparam int unsigned CW    = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;
   localparam int unsigned OW    = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic [7:0]            len_q, len_d;
   logic                  last_q, last_d;
   logic [OW-1:0]         outst_q, outst_d;
   logic                  ready_q, ready_d;
   logic                  valid_q, valid_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic                  err_q, err_d;

   logic                  desc_hs, cmd_hs, misaligned;
   logic [CW-1:0]         step, to4k, n_beats;

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      outst_d = outst_q;
      err_d   = err_q;

      desc_hs    = bus.desc_tvalid && ready_q;
      cmd_hs     = valid_q && bus.cmd_tready;
      step       = CW'(len_q) + CW'(1);
      misaligned = (|(bus.desc_base & ADDR_WIDTH'(DATA_BYTES - 1))) ||
                   (|(bus.desc_len  & LEN_WIDTH'(DATA_BYTES - 1)));

      unique case (state_q)
         S_IDLE: begin
            if (desc_hs) begin
               addr_d  = bus.desc_base & ~ADDR_WIDTH'(DATA_BYTES - 1);
               rem_d   = bus.desc_len >> OFF_W;
               state_d = (rem_d != '0) ? S_ISSUE : S_DRAIN;
               if (misaligned) err_d = 1'b1;
            end
         end
         S_ISSUE: begin
            if (cmd_hs) begin
               addr_d = addr_q + (ADDR_WIDTH'(step) << OFF_W);
               rem_d  = rem_q - LEN_WIDTH'(step);
               if (rem_d == '0) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (outst_q == '0) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Simultaneous issue and completion cancel out; a stray completion is dropped.
      unique case ({cmd_hs, bus.rdone})
         2'b10:   outst_d = outst_q + OW'(1);
         2'b01: begin
            if (outst_q != '0) outst_d = outst_q - OW'(1);
            else               err_d   = 1'b1;
         end
         default: outst_d = outst_q;
      endcase

      // Next burst size from the post-update address/remaining so the command
      // fields are ready in the register the cycle they become valid.
      to4k    = (CW'(13'h1000) - CW'(addr_d[11:0])) >> OFF_W;
      n_beats = CW'(rem_d);
      if (n_beats > CW'(MAX_BURST)) n_beats = CW'(MAX_BURST);
      if (n_beats > to4k)           n_beats = to4k;
      len_d  = 8'(n_beats - CW'(1));
      last_d = (n_beats == CW'(rem_d));

      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d != S_IDLE);
      valid_d = (state_d == S_ISSUE) && (outst_d < OW'(MAX_OUTSTANDING));
      done_d  = (state_d == S_DRAIN) && (outst_d == '0);
   end

   // State and output registers
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         len_q   <= '0;
         last_q  <= 1'b0;
         outst_q <= '0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         len_q   <= len_d;
         last_q  <= last_d;
         outst_q <= outst_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign bus.desc_tready = ready_q;
   assign bus.cmd_tvalid  = valid_q;
   assign bus.cmd_addr    = addr_q;
   assign bus.cmd_len     = len_q;
   assign bus.cmd_last    = last_q;
   assign bus.desc_done   = done_q;
   assign bus.busy        = busy_q;
   assign bus.err         = err_q;

endmodule
